// File: rtl/sel_enc_pkg.sv
// -----------------------------------------------------------------------------
// sel_enc_pkg
//   Shared types and helpers for the select priority encoder.
//   - state_e : output stage occupancy (EMPTY = no result held, FULL = result held)
//   - idx_w() : width of the encoded index for an N-bit request vector
// -----------------------------------------------------------------------------
package sel_enc_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Width of a binary index that can address n request bits.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : sel_enc_pkg

// File: rtl/sel_priority_encoder_if.sv
// -----------------------------------------------------------------------------
// sel_priority_encoder_if
//   Request/result bus of the select priority encoder.
//   Parameters : N (request width), CNT_W (delivered-result counter width)
//   Signals    : in_valid/in_ready/req      request side (master drives valid/req)
//                out_valid/out_ready         result handshake (master drives ready)
//                sel/none/xerr/cnt           result payload and delivered count
//   Modports   : master - the client issuing requests and consuming results
//                slave  - the encoder block
// -----------------------------------------------------------------------------
interface sel_priority_encoder_if #(
    parameter int N     = 8,
    parameter int CNT_W = 16
);
    import sel_enc_pkg::*;

    localparam int IDX_W = idx_w(N);

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     req;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] sel;
    logic             none;
    logic             xerr;
    logic [CNT_W-1:0] cnt;

    modport master (
        output in_valid,
        output req,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sel,
        input  none,
        input  xerr,
        input  cnt
    );

    modport slave (
        input  in_valid,
        input  req,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sel,
        output none,
        output xerr,
        output cnt
    );

endinterface : sel_priority_encoder_if

// File: rtl/sel_lsb_find.sv
// -----------------------------------------------------------------------------
// sel_lsb_find
//   Combinational lowest-set-bit search. Bit 0 has the highest priority.
//   Ports:
//     req  in  N      request vector
//     idx  out IDX_W  index of the lowest set bit (0 when req is all zeros)
//     zero out 1      req is all zeros
// -----------------------------------------------------------------------------
module sel_lsb_find
    import sel_enc_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             zero
);

    // lower_any[k] is set when any of req[k-1:0] is set; a bit is granted
    // only when nothing below it is requesting, so at most one grant is hot.
    logic [N:0]   lower_any;
    logic [N-1:0] grant;

    assign lower_any[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_grant
            assign lower_any[gi+1] = lower_any[gi] | req[gi];
            assign grant[gi]       = req[gi] & ~lower_any[gi];
        end
    endgenerate

    assign zero = ~lower_any[N];

    // One-hot to binary: OR together the indices of granted bits.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

endmodule : sel_lsb_find

// File: rtl/sel_priority_encoder.sv
// -----------------------------------------------------------------------------
// sel_priority_encoder
//   Encodes an N-bit request vector into the binary index of its lowest set
//   bit, registered behind a one-entry valid/ready output stage, and counts
//   delivered results with a saturating counter.
//   Parameters : N (2..32), CNT_W
//   Ports:
//     clk    in   single clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     bus    slave modport of sel_priority_encoder_if
//            (in_valid/in_ready/req, out_valid/out_ready, sel/none/xerr/cnt)
//   Optional build macro: REQ_XCHECK_EN
//     defined   - an accepted req holding x/z bits yields xerr=1, none=1, sel=0
//                 (simulation-only check; has no hardware meaning)
//     undefined - xerr is always 0 and req is encoded as-is
// -----------------------------------------------------------------------------
module sel_priority_encoder
    import sel_enc_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sel_priority_encoder_if.slave bus
);

    localparam int IDX_W = idx_w(N);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sel_q,   sel_d;
    logic             none_q,  none_d;
    logic             xerr_q,  xerr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [IDX_W-1:0] find_idx;
    logic             find_zero;
    logic             req_has_x;
    logic             accept;
    logic             consume;

    sel_lsb_find #(
        .N (N)
    ) u_lsb_find (
        .req  (bus.req),
        .idx  (find_idx),
        .zero (find_zero)
    );

`ifdef REQ_XCHECK_EN
    // Reduction-XOR goes to x whenever any request bit is x/z.
    assign req_has_x = ((^bus.req) === 1'bx);
`else
    assign req_has_x = 1'b0;
`endif

    // A held result can be replaced on the same edge it is consumed, which
    // keeps one transfer per cycle while the consumer is ready.
    assign bus.in_ready  = (state_q == EMPTY) | bus.out_ready;
    assign accept        = bus.in_valid & bus.in_ready;
    assign consume       = (state_q == FULL) & bus.out_ready;

    assign bus.out_valid = (state_q == FULL);
    assign bus.sel       = sel_q;
    assign bus.none      = none_q;
    assign bus.xerr      = xerr_q;
    assign bus.cnt       = cnt_q;

    // Next-state and result load.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        none_d  = none_q;
        xerr_d  = xerr_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (bus.out_ready && !bus.in_valid) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (accept) begin
            if (req_has_x) begin
                sel_d  = '0;
                none_d = 1'b1;
                xerr_d = 1'b1;
            end else begin
                sel_d  = find_idx;
                none_d = find_zero;
                xerr_d = 1'b0;
            end
        end
    end

    // Delivered-result counter, holds at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (consume && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            sel_q   <= '0;
            none_q  <= 1'b0;
            xerr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            none_q  <= none_d;
            xerr_q  <= xerr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : sel_priority_encoder

// File: tb/tb_sel_priority_encoder.sv
// -----------------------------------------------------------------------------
// tb_sel_priority_encoder
//   Directed stimulus with a queue-based scoreboard. The driver pushes the
//   hand-computed result of every accepted request; an independent monitor
//   pops and compares each time a result is consumed, and also tracks the
//   delivered-result count and output stability under backpressure.
// -----------------------------------------------------------------------------
module tb_sel_priority_encoder;

    localparam int N     = 8;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic       xerr;
        logic       none;
        logic [2:0] sel;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sel_priority_encoder_if #(.N(N), .CNT_W(CNT_W)) bus ();

    sel_priority_encoder #(
        .N     (N),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    exp_t       sb_q[$];
    int         tests = 0;
    int         fails = 0;
    logic [3:0] cnt_exp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Entered at posedge+1; applies inputs, records the expected result if
    // the request is taken, and returns at the next posedge+1.
    task automatic drive(input logic v, input logic [7:0] r, input logic ordy,
                         input logic [2:0] es, input logic en);
        exp_t e;
        bus.in_valid  = v;
        bus.req       = r;
        bus.out_ready = ordy;
        @(negedge clk);
        if (v && bus.in_ready) begin
            e.xerr = 1'b0;
            e.none = en;
            e.sel  = es;
            sb_q.push_back(e);
            $display("[TB] issue req=%08b expect sel=%0d none=%0b", r, es, en);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    logic       hold_pend = 1'b0;
    logic [2:0] hold_sel  = '0;
    logic       hold_none = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                cnt_exp   = '0;
                hold_pend = 1'b0;
                continue;
            end
            check("cnt", 32'(bus.cnt), 32'(cnt_exp));
            if (hold_pend) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_sel", 32'(bus.sel), 32'(hold_sel));
                check("hold_none", 32'(bus.none), 32'(hold_none));
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_sel  = bus.sel;
            hold_none = bus.none;
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_result: got sel=%0d, expected no result", bus.sel);
                end else begin
                    e = sb_q.pop_front();
                    $display("[TB] result sel=%0d none=%0b xerr=%0b", bus.sel, bus.none, bus.xerr);
                    check("sel", 32'(bus.sel), 32'(e.sel));
                    check("none", 32'(bus.none), 32'(e.none));
                    check("xerr", 32'(bus.xerr), 32'(e.xerr));
                end
                if (cnt_exp != 4'hF) cnt_exp = cnt_exp + 4'd1;
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    logic [7:0] vec_req [8] = '{8'b1010_1000, 8'h80, 8'h01, 8'hFF, 8'h40, 8'h06, 8'h00, 8'h30};
    logic [2:0] vec_sel [8] = '{3'd3, 3'd7, 3'd0, 3'd0, 3'd6, 3'd1, 3'd0, 3'd4};
    logic       vec_none[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        bus.in_valid  = 1'b0;
        bus.req       = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sel", 32'(bus.sel), 32'd0);
        check("rst_none", 32'(bus.none), 32'd0);
        check("rst_xerr", 32'(bus.xerr), 32'd0);
        check("rst_cnt", 32'(bus.cnt), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Priority encode, back-to-back
        drive(1'b1, 8'b1010_1000, 1'b1, 3'd3, 1'b0);
        check("lat_out_valid", 32'(bus.out_valid), 32'd1);
        drive(1'b1, 8'h80, 1'b1, 3'd7, 1'b0);
        drive(1'b1, 8'h01, 1'b1, 3'd0, 1'b0);
        drive(1'b1, 8'hFF, 1'b1, 3'd0, 1'b0);
        drive(1'b1, 8'h40, 1'b1, 3'd6, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);

        // Zero vector
        drive(1'b1, 8'h00, 1'b1, 3'd0, 1'b1);
        check("zero_out_valid", 32'(bus.out_valid), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 3'd0, 1'b0);

        // Backpressure: result 2 held while req keeps changing
        drive(1'b1, 8'h04, 1'b0, 3'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid  = 1'b1;
            bus.req       = 8'h10 << (i % 3);
            bus.out_ready = 1'b0;
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_sel", 32'(bus.sel), 32'd2);
            @(posedge clk);
            #1;
        end
        drive(1'b1, 8'h20, 1'b1, 3'd5, 1'b0);
        check("bp_resume_sel", 32'(bus.sel), 32'd5);
        drive(1'b1, 8'h08, 1'b1, 3'd3, 1'b0);
        check("bp_tp_valid", 32'(bus.out_valid), 32'd1);
        drive(1'b1, 8'h02, 1'b1, 3'd1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 3'd0, 1'b0);

        // Asynchronous reset with a result pending
        drive(1'b1, 8'h40, 1'b0, 3'd6, 1'b0);
        check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_cnt", 32'(bus.cnt), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_sel", 32'(bus.sel), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 20 back-to-back transfers, counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, vec_req[i % 8], 1'b1, vec_sel[i % 8], vec_none[i % 8]);
            check("tp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        drive(1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
        check("sat_cnt", 32'(bus.cnt), 32'hF);
        check("sat_xerr", 32'(bus.xerr), 32'd0);

`ifdef REQ_XCHECK_EN
        begin
            logic [7:0] xreq;
            exp_t       ex;
            xreq = 8'b0000_00x0;
            bus.in_valid  = 1'b1;
            bus.req       = xreq;
            bus.out_ready = 1'b1;
            @(negedge clk);
            ex.xerr = 1'b1;
            ex.none = 1'b1;
            ex.sel  = 3'd0;
            if (bus.in_ready) sb_q.push_back(ex);
            @(posedge clk);
            #1;
            drive(1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
        end
`endif

        // Bounded drain
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sel_priority_encoder
